// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file: two registered read ports with write-first bypass,
// one write port, optional hardwired-zero entry 0 and a sequenced clear-all.
//
// state   | meaning
// S_IDLE  | normal read/write operation, busy low
// S_CLEAR | zeroing entry[idx] each cycle, writes and clr ignored, busy high
module regfile_2r1w #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re_a,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [WIDTH-1:0] o_rdata_a,
  input  logic             i_re_b,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_b,
  input  logic             i_clr,
  output logic             o_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam int         LAST     = DEPTH - 1;
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  localparam logic [AW:0] LAST_W  = LAST[AW:0];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW:0]      r_idx;
  logic [AW:0]      w_idx_nxt;
  logic             r_busy;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_b;

  logic             w_wr_req;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;
  logic             w_byp_en;
  logic             w_rd_a_ok;
  logic             w_rd_b_ok;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // A write is legal only in range and not aimed at the hardwired-zero entry.
  assign w_wr_req  = i_we && ({1'b0, i_waddr} < DEPTH_W)
                     && !((ZERO_REG != 0) && (i_waddr == '0));
  assign w_rd_a_ok = ({1'b0, i_raddr_a} < DEPTH_W)
                     && !((ZERO_REG != 0) && (i_raddr_a == '0));
  assign w_rd_b_ok = ({1'b0, i_raddr_b} < DEPTH_W)
                     && !((ZERO_REG != 0) && (i_raddr_b == '0));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= (w_state_nxt == S_CLEAR);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_clr) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_idx == LAST_W) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = i_waddr;
    w_mem_wdata = i_wdata;
    w_idx_nxt   = r_idx;
    w_byp_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mem_we = w_wr_req;
        w_byp_en = w_wr_req;
        if (i_clr) w_idx_nxt = '0;
      end
      S_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_idx[AW-1:0];
        w_mem_wdata = '0;
        w_idx_nxt   = r_idx + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (w_rd_a_ok) w_rd_a = (w_byp_en && (i_waddr == i_raddr_a)) ? i_wdata : r_mem[i_raddr_a];
    if (w_rd_b_ok) w_rd_b = (w_byp_en && (i_waddr == i_raddr_b)) ? i_wdata : r_mem[i_raddr_b];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (i_re_a) r_rdata_a <= w_rd_a;
      if (i_re_b) r_rdata_b <= w_rd_b;
    end
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed vector table, clear/reset sequences and random
// traffic, checked on a DEPTH=8 and a DEPTH=6 instance against a reference model.
module tb_regfile_2r1w;

  logic       clk = 1'b0;
  logic       rst, we, re_a, re_b, clr;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [7:0] ra [2];
  logic [7:0] rb [2];
  logic       bsy [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .AW(3), .ZERO_REG(1)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_re_a(re_a), .i_raddr_a(raddr_a), .o_rdata_a(ra[0]),
    .i_re_b(re_b), .i_raddr_b(raddr_b), .o_rdata_b(rb[0]),
    .i_clr(clr), .o_busy(bsy[0]));

  regfile_2r1w #(.WIDTH(8), .DEPTH(6), .AW(3), .ZERO_REG(1)) u_dut6 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_re_a(re_a), .i_raddr_a(raddr_a), .o_rdata_a(ra[1]),
    .i_re_b(re_b), .i_raddr_b(raddr_b), .o_rdata_b(rb[1]),
    .i_clr(clr), .o_busy(bsy[1]));

  // Reference model: contents array plus "clear cycles remaining" per instance.
  logic [7:0] m_mem [2][8];
  logic [7:0] m_ra  [2];
  logic [7:0] m_rb  [2];
  int         m_cnt [2];

  function automatic int depth_of(int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [7:0] model_read(int k, logic [2:0] a, logic wr_ok);
    if (int'(a) >= depth_of(k) || a == 3'd0) return 8'h00;
    if (wr_ok && a == waddr) return wdata;
    return m_mem[k][a];
  endfunction

  task automatic model_step(int k);
    logic wr_ok;
    int   d;
    d = depth_of(k);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
      m_ra[k] = 8'h00; m_rb[k] = 8'h00; m_cnt[k] = 0;
      return;
    end
    wr_ok = (m_cnt[k] == 0) && we && (int'(waddr) < d) && (waddr != 3'd0);
    if (re_a) m_ra[k] = model_read(k, raddr_a, wr_ok);
    if (re_b) m_rb[k] = model_read(k, raddr_b, wr_ok);
    if (m_cnt[k] > 0) begin
      m_mem[k][d - m_cnt[k]] = 8'h00;
      m_cnt[k]--;
    end else begin
      if (wr_ok) m_mem[k][waddr] = wdata;
      if (clr) m_cnt[k] = d;
    end
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_rdata_a[d%0d]", depth_of(k)), ra[k], m_ra[k]);
      chk($sformatf("model_rdata_b[d%0d]", depth_of(k)), rb[k], m_rb[k]);
      chk($sformatf("model_busy[d%0d]", depth_of(k)), {7'd0, bsy[k]}, {7'd0, m_cnt[k] > 0});
    end
  endtask

  task automatic idle_in();
    rst = 0; we = 0; re_a = 0; re_b = 0; clr = 0;
    waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
  endtask

  task automatic do_write(logic [2:0] a, logic [7:0] d);
    idle_in(); we = 1; waddr = a; wdata = d; tick();
  endtask

  task automatic do_read_a(logic [2:0] a);
    idle_in(); re_a = 1; raddr_a = a; tick();
  endtask

  typedef struct {
    logic       rst, we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       rea;
    logic [2:0] ra;
    logic       reb;
    logic [2:0] rb;
    logic       clr;
    logic [7:0] ea, eb;
    logic       ebusy;
  } vec_t;

  vec_t vt [9];
  int   nb8, nb6;

  initial begin
    idle_in();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ra[k] = 8'h00; m_rb[k] = 8'h00;
      for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
    end

    //         rst we wa    wd     rea ra    reb rb    clr ea     eb     busy
    vt[0] = '{1, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 0, 8'h00, 8'h00, 0};
    vt[1] = '{0, 0, 3'd0, 8'h00, 1, 3'd3, 0, 3'd0, 0, 8'h00, 8'h00, 0};
    vt[2] = '{0, 1, 3'd3, 8'hA5, 0, 3'd0, 0, 3'd0, 0, 8'h00, 8'h00, 0};
    vt[3] = '{0, 0, 3'd0, 8'h00, 1, 3'd3, 0, 3'd0, 0, 8'hA5, 8'h00, 0};
    vt[4] = '{0, 0, 3'd0, 8'h00, 0, 3'd4, 0, 3'd0, 0, 8'hA5, 8'h00, 0};
    vt[5] = '{0, 1, 3'd5, 8'h3C, 1, 3'd5, 1, 3'd5, 0, 8'h3C, 8'h3C, 0};
    vt[6] = '{0, 1, 3'd0, 8'hFF, 0, 3'd0, 0, 3'd0, 0, 8'h3C, 8'h3C, 0};
    vt[7] = '{0, 0, 3'd0, 8'h00, 1, 3'd0, 1, 3'd5, 0, 8'h00, 8'h3C, 0};
    vt[8] = '{0, 0, 3'd0, 8'h00, 1, 3'd7, 1, 3'd3, 0, 8'h00, 8'hA5, 0};

    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
      re_a = vt[i].rea; raddr_a = vt[i].ra; re_b = vt[i].reb; raddr_b = vt[i].rb;
      clr = vt[i].clr;
      tick();
      chk($sformatf("vec%0d_rdata_a", i), ra[0], vt[i].ea);
      chk($sformatf("vec%0d_rdata_b", i), rb[0], vt[i].eb);
      chk($sformatf("vec%0d_busy", i), {7'd0, bsy[0]}, {7'd0, vt[i].ebusy});
    end

    // Clear sequence: fill, clear, count busy cycles, write while busy is dropped.
    for (int i = 1; i < 8; i++) do_write(3'(i), 8'(i * 8'h11));
    idle_in(); clr = 1; tick();
    nb8 = 0; nb6 = 0;
    for (int n = 0; n < 20 && (bsy[0] || bsy[1]); n++) begin
      if (bsy[0]) nb8++;
      if (bsy[1]) nb6++;
      idle_in();
      if (n == 0) begin we = 1; waddr = 3'd7; wdata = 8'h99; end
      tick();
    end
    chk("clear_busy_cycles_d8", 8'(nb8), 8'd8);
    chk("clear_busy_cycles_d6", 8'(nb6), 8'd6);
    for (int i = 1; i < 8; i++) begin
      do_read_a(3'(i));
      chk($sformatf("after_clear_addr%0d", i), ra[0], 8'h00);
    end

    // Reset in the middle of a clear.
    do_write(3'd6, 8'h66);
    idle_in(); clr = 1; tick();
    idle_in(); tick();
    idle_in(); tick();
    chk("midclear_busy_before_rst", {7'd0, bsy[0]}, 8'd1);
    idle_in(); rst = 1; tick();
    chk("midclear_rst_busy", {7'd0, bsy[0]}, 8'd0);
    chk("midclear_rst_rdata_a", ra[0], 8'h00);
    do_write(3'd2, 8'h42);
    do_read_a(3'd2);
    chk("after_rst_write_read", ra[0], 8'h42);
    do_read_a(3'd6);
    chk("after_rst_entry6", ra[0], 8'h00);

    // Out of range on the DEPTH=6 instance.
    do_write(3'd7, 8'hEE);
    do_read_a(3'd7);
    chk("oor_d6_read7", ra[1], 8'h00);
    chk("inrange_d8_read7", ra[0], 8'hEE);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      clr     = ($urandom_range(0, 24) == 0);
      we      = $urandom_range(0, 1);
      waddr   = 3'($urandom_range(0, 7));
      wdata   = 8'($urandom);
      re_a    = ($urandom_range(0, 3) != 0);
      re_b    = ($urandom_range(0, 3) != 0);
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
